// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between LDR and ALU writeback.
// LDR always wins; displaced ALU writes wait in a small in-order pending FIFO.
module regfile_wb_arbiter #(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 4,
  parameter  int DEPTH  = 2,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_wr_en,
  input  logic [ADDR_W-1:0] alu_wr_addr,
  input  logic [DATA_W-1:0] alu_wr_data,
  input  logic              ldr_wr_en,
  input  logic [ADDR_W-1:0] ldr_wr_addr,
  input  logic [DATA_W-1:0] ldr_wr_data,
  input  logic [ADDR_W-1:0] query_addr,
  output logic              rf_w_en,
  output logic [ADDR_W-1:0] rf_w_addr,
  output logic [DATA_W-1:0] rf_w_data,
  output logic              query_hit,
  output logic              stall_req,
  output logic [CNT_W-1:0]  pend_count,
  output logic              overflow
);

  logic [DEPTH-1:0]  q_valid;
  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];

  logic [DEPTH-1:0]  n_valid;
  logic [ADDR_W-1:0] n_addr [DEPTH];
  logic [DATA_W-1:0] n_data [DEPTH];

  logic              sel_en;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              pop;
  logic              push;
  logic              drop;
  int                slot;

  // Entries stay packed with the oldest at index 0, so killed entries leave
  // no holes and the head is always slot 0.
  always_comb begin
    n_valid  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      n_addr[i] = q_addr[i];
      n_data[i] = q_data[i];
    end
    sel_en   = 1'b0;
    sel_addr = ldr_wr_addr;
    sel_data = ldr_wr_data;
    pop      = 1'b0;
    drop     = 1'b0;
    slot     = 0;

    if (ldr_wr_en) begin
      sel_en = 1'b1;
    end else if (q_valid[0]) begin
      sel_en   = 1'b1;
      sel_addr = q_addr[0];
      sel_data = q_data[0];
      pop      = 1'b1;
    end else if (alu_wr_en) begin
      sel_en   = 1'b1;
      sel_addr = alu_wr_addr;
      sel_data = alu_wr_data;
    end

    push = alu_wr_en && (ldr_wr_en || q_valid[0]);

    // Survivors: not popped, and not superseded by a younger LDR to the same register.
    for (int i = 0; i < DEPTH; i++) begin
      if (q_valid[i] && !(pop && i == 0) &&
          !(ldr_wr_en && q_addr[i] == ldr_wr_addr)) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (j == slot) begin
            n_valid[j] = 1'b1;
            n_addr[j]  = q_addr[i];
            n_data[j]  = q_data[i];
          end
        end
        slot = slot + 1;
      end
    end

    if (push) begin
      if (slot < DEPTH) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (j == slot) begin
            n_valid[j] = 1'b1;
            n_addr[j]  = alu_wr_addr;
            n_data[j]  = alu_wr_data;
          end
        end
      end else begin
        drop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_addr[i] <= '0;
        q_data[i] <= '0;
      end
      rf_w_en   <= 1'b0;
      rf_w_addr <= '0;
      rf_w_data <= '0;
      overflow  <= 1'b0;
    end else begin
      q_valid <= n_valid;
      for (int i = 0; i < DEPTH; i++) begin
        q_addr[i] <= n_addr[i];
        q_data[i] <= n_data[i];
      end
      rf_w_en <= sel_en;
      if (sel_en) begin
        rf_w_addr <= sel_addr;
        rf_w_data <= sel_data;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    pend_count = '0;
    query_hit  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_count = pend_count + CNT_W'(q_valid[i]);
      if (q_valid[i] && q_addr[i] == query_addr) begin
        query_hit = 1'b1;
      end
    end
  end

  assign stall_req = (pend_count >= CNT_W'(DEPTH - 1));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table, reset
// corner case, then randomized traffic against a queue-based reference model.
module tb_regfile_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst_n;
  logic              alu_wr_en;
  logic [ADDR_W-1:0] alu_wr_addr;
  logic [DATA_W-1:0] alu_wr_data;
  logic              ldr_wr_en;
  logic [ADDR_W-1:0] ldr_wr_addr;
  logic [DATA_W-1:0] ldr_wr_data;
  logic [ADDR_W-1:0] query_addr;
  logic              rf_w_en;
  logic [ADDR_W-1:0] rf_w_addr;
  logic [DATA_W-1:0] rf_w_data;
  logic              query_hit;
  logic              stall_req;
  logic [CNT_W-1:0]  pend_count;
  logic              overflow;

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_wr_en(alu_wr_en), .alu_wr_addr(alu_wr_addr), .alu_wr_data(alu_wr_data),
    .ldr_wr_en(ldr_wr_en), .ldr_wr_addr(ldr_wr_addr), .ldr_wr_data(ldr_wr_data),
    .query_addr(query_addr),
    .rf_w_en(rf_w_en), .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data),
    .query_hit(query_hit), .stall_req(stall_req), .pend_count(pend_count),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              a_en;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              l_en;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_data;
    logic [ADDR_W-1:0] q_addr;
    logic              e_en;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    logic [CNT_W-1:0]  e_cnt;
    logic              e_stall;
    logic              e_hit;
    logic              e_ovf;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending ALU writes as an ordered queue.
  entry_t            mq[$];
  logic              m_en;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic              m_ovf;

  task automatic modelReset();
    mq.delete();
    m_en = 1'b0; m_addr = '0; m_data = '0; m_ovf = 1'b0;
  endtask

  task automatic modelStep();
    int     sz0;
    entry_t e;
    entry_t keep[$];
    sz0  = mq.size();
    m_en = 1'b0;
    if (ldr_wr_en) begin
      m_en = 1'b1; m_addr = ldr_wr_addr; m_data = ldr_wr_data;
      foreach (mq[i]) if (mq[i].addr != ldr_wr_addr) keep.push_back(mq[i]);
      mq = keep;
    end else if (sz0 > 0) begin
      e = mq.pop_front();
      m_en = 1'b1; m_addr = e.addr; m_data = e.data;
    end else if (alu_wr_en) begin
      m_en = 1'b1; m_addr = alu_wr_addr; m_data = alu_wr_data;
    end
    if (alu_wr_en && (ldr_wr_en || sz0 > 0)) begin
      if (mq.size() < DEPTH) begin
        e.addr = alu_wr_addr; e.data = alu_wr_data;
        mq.push_back(e);
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  function automatic vec_t modelExp();
    vec_t v;
    v = '{default: '0};
    v.e_en    = m_en;
    v.e_addr  = m_addr;
    v.e_data  = m_data;
    v.e_cnt   = CNT_W'(mq.size());
    v.e_stall = (mq.size() >= DEPTH - 1);
    v.e_hit   = 1'b0;
    foreach (mq[i]) if (mq[i].addr == query_addr) v.e_hit = 1'b1;
    v.e_ovf   = m_ovf;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s (vector %0d): got %h, expected %h", name, n_vec, act, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v);
    n_vec++;
    cmp("rf_w_en",    DATA_W'(rf_w_en),    DATA_W'(v.e_en));
    cmp("rf_w_addr",  DATA_W'(rf_w_addr),  DATA_W'(v.e_addr));
    cmp("rf_w_data",  rf_w_data,           v.e_data);
    cmp("pend_count", DATA_W'(pend_count), DATA_W'(v.e_cnt));
    cmp("stall_req",  DATA_W'(stall_req),  DATA_W'(v.e_stall));
    cmp("query_hit",  DATA_W'(query_hit),  DATA_W'(v.e_hit));
    cmp("overflow",   DATA_W'(overflow),   DATA_W'(v.e_ovf));
  endtask

  task automatic applyStimulus(input vec_t v);
    alu_wr_en = v.a_en; alu_wr_addr = v.a_addr; alu_wr_data = v.a_data;
    ldr_wr_en = v.l_en; ldr_wr_addr = v.l_addr; ldr_wr_data = v.l_data;
    query_addr = v.q_addr;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic doReset();
    alu_wr_en = 1'b0; alu_wr_addr = '0; alu_wr_data = '0;
    ldr_wr_en = 1'b0; ldr_wr_addr = '0; ldr_wr_data = '0;
    query_addr = '0;
    rst_n = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput(modelExp());
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[20];
  vec_t rv;

  initial begin
    //           alu en/addr/data       ldr en/addr/data       query  exp en/addr/data          cnt  stall hit  ovf
    tbl[0]  = '{1'b1,4'h3,32'hA5, 1'b0,4'h0,32'h00, 4'h0, 1'b1,4'h3,32'hA5, 2'd0,1'b0,1'b0,1'b0};
    tbl[1]  = '{1'b0,4'h0,32'h00, 1'b0,4'h0,32'h00, 4'h0, 1'b0,4'h3,32'hA5, 2'd0,1'b0,1'b0,1'b0};
    tbl[2]  = '{1'b1,4'h2,32'h22, 1'b1,4'h1,32'h11, 4'h2, 1'b1,4'h1,32'h11, 2'd1,1'b1,1'b1,1'b0};
    tbl[3]  = '{1'b0,4'h0,32'h00, 1'b0,4'h0,32'h00, 4'h2, 1'b1,4'h2,32'h22, 2'd0,1'b0,1'b0,1'b0};
    tbl[4]  = '{1'b1,4'h9,32'h91, 1'b1,4'h8,32'h81, 4'h0, 1'b1,4'h8,32'h81, 2'd1,1'b1,1'b0,1'b0};
    tbl[5]  = '{1'b1,4'hB,32'h92, 1'b1,4'hA,32'h82, 4'h0, 1'b1,4'hA,32'h82, 2'd2,1'b1,1'b0,1'b0};
    tbl[6]  = '{1'b1,4'hD,32'h93, 1'b1,4'hC,32'h83, 4'h0, 1'b1,4'hC,32'h83, 2'd2,1'b1,1'b0,1'b1};
    tbl[7]  = '{1'b0,4'h0,32'h00, 1'b0,4'h0,32'h00, 4'h0, 1'b1,4'h9,32'h91, 2'd1,1'b1,1'b0,1'b1};
    tbl[8]  = '{1'b0,4'h0,32'h00, 1'b0,4'h0,32'h00, 4'h0, 1'b1,4'hB,32'h92, 2'd0,1'b0,1'b0,1'b1};
    tbl[9]  = '{1'b0,4'h0,32'h00, 1'b0,4'h0,32'h00, 4'h0, 1'b0,4'hB,32'h92, 2'd0,1'b0,1'b0,1'b1};
    tbl[10] = '{1'b1,4'h5,32'h55, 1'b1,4'h4,32'h44, 4'h0, 1'b1,4'h4,32'h44, 2'd1,1'b1,1'b0,1'b1};
    tbl[11] = '{1'b0,4'h0,32'h00, 1'b1,4'h5,32'h99, 4'h5, 1'b1,4'h5,32'h99, 2'd0,1'b0,1'b0,1'b1};
    tbl[12] = '{1'b0,4'h0,32'h00, 1'b0,4'h0,32'h00, 4'h5, 1'b0,4'h5,32'h99, 2'd0,1'b0,1'b0,1'b1};
    tbl[13] = '{1'b1,4'h7,32'h77, 1'b1,4'h1,32'h01, 4'h7, 1'b1,4'h1,32'h01, 2'd1,1'b1,1'b1,1'b1};
    tbl[14] = '{1'b1,4'h3,32'h33, 1'b1,4'h2,32'h02, 4'h6, 1'b1,4'h2,32'h02, 2'd2,1'b1,1'b0,1'b1};
    tbl[15] = '{1'b0,4'h0,32'h00, 1'b0,4'h0,32'h00, 4'h7, 1'b1,4'h7,32'h77, 2'd1,1'b1,1'b0,1'b1};
    tbl[16] = '{1'b0,4'h0,32'h00, 1'b0,4'h0,32'h00, 4'h0, 1'b1,4'h3,32'h33, 2'd0,1'b0,1'b0,1'b1};
    tbl[17] = '{1'b1,4'h2,32'h20, 1'b1,4'h1,32'h10, 4'h0, 1'b1,4'h1,32'h10, 2'd1,1'b1,1'b0,1'b1};
    tbl[18] = '{1'b1,4'h4,32'h40, 1'b0,4'h0,32'h00, 4'h0, 1'b1,4'h2,32'h20, 2'd1,1'b1,1'b0,1'b1};
    tbl[19] = '{1'b0,4'h0,32'h00, 1'b0,4'h0,32'h00, 4'h0, 1'b1,4'h4,32'h40, 2'd0,1'b0,1'b0,1'b1};

    doReset();
    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      checkOutput(tbl[i]);
    end

    // Fill the FIFO to two entries, then pulse reset in the middle of a cycle.
    rv = '{default: '0};
    rv.a_en = 1'b1; rv.a_addr = 4'h2; rv.a_data = 32'h2222;
    rv.l_en = 1'b1; rv.l_addr = 4'h1; rv.l_data = 32'h1111;
    applyStimulus(rv);
    checkOutput(modelExp());
    rv.a_addr = 4'h4; rv.a_data = 32'h4444; rv.l_addr = 4'h3; rv.l_data = 32'h3333;
    applyStimulus(rv);
    checkOutput(modelExp());
    alu_wr_en = 1'b0; ldr_wr_en = 1'b0;
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput(modelExp());
    @(negedge clk);
    rst_n = 1'b1;
    rv = '{default: '0};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(rv);
      checkOutput(modelExp());
    end

    // Randomized traffic, reset between rounds so overflow is re-exercised.
    for (int r = 0; r < 3; r++) begin
      doReset();
      for (int i = 0; i < 150; i++) begin
        rv = '{default: '0};
        rv.a_en   = ($urandom_range(0, 99) < 55);
        rv.a_addr = ADDR_W'($urandom_range(0, 3));
        rv.a_data = $urandom;
        rv.l_en   = ($urandom_range(0, 99) < 30 + 10 * r);
        rv.l_addr = ADDR_W'($urandom_range(0, 3));
        rv.l_data = $urandom;
        rv.q_addr = ADDR_W'($urandom_range(0, 3));
        applyStimulus(rv);
        checkOutput(modelExp());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
